// File: rtl/sram_wb_pkg.sv
// -----------------------------------------------------------------------------
// sram_wb_pkg
// Shared definitions for the Wishbone-to-asynchronous-SRAM controller:
// controller state encoding and the width of the wait/turnaround counter.
// No ports.
// -----------------------------------------------------------------------------
package sram_wb_pkg;

    // Wait and turnaround counts are 0..15, so four bits cover every setting.
    localparam int CNT_W = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_TURN  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_READ  = ST_READ,
        S_WRITE = ST_WRITE,
        S_HOLD  = ST_HOLD,
        S_TURN  = ST_TURN
    } state_e;

endpackage

// File: rtl/sram_wb_timer.sv
// -----------------------------------------------------------------------------
// sram_wb_timer
// Loadable down-counter used for SRAM wait states and read-to-write
// turnaround. Loads a value, decrements towards zero on request and stops
// there (no wrap). o_done is high whenever the count is zero.
//
// Ports:
//   clk_i     in   system clock
//   _reset_i  in   synchronous active-low reset (count cleared)
//   i_load    in   load i_value (has priority over i_dec)
//   i_value   in   value to load
//   i_dec     in   decrement by one if not already zero
//   o_done    out  count is zero
// -----------------------------------------------------------------------------
module sram_wb_timer
    import sram_wb_pkg::*;
(
    input  logic             clk_i,
    input  logic             _reset_i,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    input  logic             i_dec,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its neighbours, exactly like the hardware does.
    always_ff @(posedge clk_i) begin
        if (!_reset_i) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sram_wb.sv
// -----------------------------------------------------------------------------
// sram_wb
// Wishbone B4 pipelined slave in front of an asynchronous static RAM.
// One access at a time; the master is held off with stall_o while an access,
// its write hold cycle or the post-read bus turnaround is in progress. All
// SRAM-side signals come straight from flops.
//
// Parameters:
//   DW       data width (multiple of 8), byte lanes = DW/8
//   AW       word-address width
//   WAIT_RD  extra read cycles with _sram_oe low (0..15)
//   WAIT_WR  extra write cycles with _sram_we low (0..15)
//   TURN     idle cycles after a read before the next access (0..3)
//
// Ports:
//   clk_i, _reset_i            clock, synchronous active-low reset
//   cyc_i, stb_i, we_i         Wishbone cycle / strobe / write enable
//   sel_i [DW/8]               byte selects
//   adr_i [AW], dat_i [DW]     word address, write data
//   ack_o                      acknowledge, gated by cyc_i
//   dat_o [DW]                 read data, held between reads
//   stall_o                    request not accepted this cycle
//   _sram_ce/_we/_oe           active-low SRAM strobes
//   _sram_be [DW/8]            active-low byte enables
//   sram_a [AW]                SRAM address
//   sram_d_out [DW], sram_d_oe write data and its pin-drive enable
//   sram_d_in [DW]             data read back from the pins
// -----------------------------------------------------------------------------
module sram_wb
    import sram_wb_pkg::*;
#(
    parameter int DW      = 16,
    parameter int AW      = 19,
    parameter int WAIT_RD = 1,
    parameter int WAIT_WR = 1,
    parameter int TURN    = 1
) (
    input  logic            clk_i,
    input  logic            _reset_i,
    input  logic            cyc_i,
    input  logic            stb_i,
    input  logic            we_i,
    input  logic [DW/8-1:0] sel_i,
    input  logic [AW-1:0]   adr_i,
    input  logic [DW-1:0]   dat_i,
    output logic            ack_o,
    output logic [DW-1:0]   dat_o,
    output logic            stall_o,
    output logic            _sram_ce,
    output logic            _sram_we,
    output logic            _sram_oe,
    output logic [DW/8-1:0] _sram_be,
    output logic [AW-1:0]   sram_a,
    output logic [DW-1:0]   sram_d_out,
    output logic            sram_d_oe,
    input  logic [DW-1:0]   sram_d_in
);

    localparam logic [CNT_W-1:0] RD_LD    = CNT_W'(WAIT_RD);
    localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WAIT_WR);
    localparam bit               HAS_TURN = (TURN > 0);
    // The timer counts its loaded value down to zero, so TURN idle cycles
    // need a load of TURN-1.
    localparam logic [CNT_W-1:0] TURN_LD  = HAS_TURN ? CNT_W'(TURN - 1) : '0;

    state_e r_state;
    state_e w_next;

    logic             w_accept;
    logic             w_rd_last;
    logic             w_wr_last;
    logic             w_hold_end;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_done;

    logic            r_ack;
    logic [DW-1:0]   r_dat;
    logic            r_ce;
    logic            r_we;
    logic            r_oe;
    logic [DW/8-1:0] r_be;
    logic [AW-1:0]   r_a;
    logic [DW-1:0]   r_dout;
    logic            r_doe;

    sram_wb_timer u_timer (
        .clk_i    (clk_i),
        ._reset_i (_reset_i),
        .i_load   (w_load),
        .i_value  (w_load_val),
        .i_dec    (w_dec),
        .o_done   (w_done)
    );

    always_ff @(posedge clk_i) begin
        if (!_reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_rd_last  = 1'b0;
        w_wr_last  = 1'b0;
        w_hold_end = 1'b0;
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cyc_i && stb_i) begin
                    w_accept   = 1'b1;
                    w_load     = 1'b1;
                    w_load_val = we_i ? WR_LD : RD_LD;
                    w_next     = we_i ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                if (w_done) begin
                    w_rd_last = 1'b1;
                    if (HAS_TURN) begin
                        w_load     = 1'b1;
                        w_load_val = TURN_LD;
                        w_next     = S_TURN;
                    end else begin
                        w_next = S_IDLE;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_WRITE: begin
                if (w_done) begin
                    w_wr_last = 1'b1;
                    w_next    = S_HOLD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_HOLD: begin
                w_hold_end = 1'b1;
                w_next     = S_IDLE;
            end
            S_TURN: begin
                if (w_done) begin
                    w_next = S_IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // SRAM pin registers. Address, byte enables and write data stay put after
    // an access, so they are already stable through the write hold cycle.
    always_ff @(posedge clk_i) begin
        if (!_reset_i) begin
            r_ack  <= 1'b0;
            r_dat  <= '0;
            r_ce   <= 1'b1;
            r_we   <= 1'b1;
            r_oe   <= 1'b1;
            r_be   <= '1;
            r_a    <= '0;
            r_dout <= '0;
            r_doe  <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_accept) begin
                r_a    <= adr_i;
                r_be   <= ~sel_i;
                r_dout <= dat_i;
                r_ce   <= 1'b0;
                if (we_i) begin
                    r_we  <= 1'b0;
                    r_doe <= 1'b1;
                end else begin
                    r_oe <= 1'b0;
                end
            end
            if (w_rd_last) begin
                r_dat <= sram_d_in;
                r_ack <= 1'b1;
                r_oe  <= 1'b1;
                r_ce  <= 1'b1;
            end
            // Data drive and chip enable outlive _sram_we by one cycle to
            // give the SRAM its data hold time.
            if (w_wr_last) begin
                r_we  <= 1'b1;
                r_ack <= 1'b1;
            end
            if (w_hold_end) begin
                r_doe <= 1'b0;
                r_ce  <= 1'b1;
            end
        end
    end

    // A master that drops cyc_i abandons the cycle: the SRAM access still
    // finishes cleanly, but the acknowledge is not presented.
    assign ack_o      = r_ack & cyc_i;
    assign dat_o      = r_dat;
    assign stall_o    = (r_state != S_IDLE);
    assign _sram_ce   = r_ce;
    assign _sram_we   = r_we;
    assign _sram_oe   = r_oe;
    assign _sram_be   = r_be;
    assign sram_a     = r_a;
    assign sram_d_out = r_dout;
    assign sram_d_oe  = r_doe;

endmodule

// File: tb/tb_sram_wb.sv
// -----------------------------------------------------------------------------
// tb_sram_wb
// Self-checking bench for sram_wb. Instance A: DW=16, AW=19, WAIT_RD=1,
// WAIT_WR=2, TURN=1, attached to a small behavioural SRAM. Instance B:
// DW=32, AW=18, WAIT_RD=0, TURN=0, whose pins return a pattern derived from
// the address.
// -----------------------------------------------------------------------------
module tb_sram_wb;

    localparam int A_RD   = 1;
    localparam int A_WR   = 2;
    localparam int A_TURN = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A ----------------
    logic        a_cyc, a_stb, a_we;
    logic [1:0]  a_sel;
    logic [18:0] a_adr;
    logic [15:0] a_dat;
    logic        a_ack, a_stall, a_ce, a_wen, a_oe, a_doe;
    logic [15:0] a_dout, a_dq, a_din;
    logic [1:0]  a_be;
    logic [18:0] a_sa;

    sram_wb #(.DW(16), .AW(19), .WAIT_RD(A_RD), .WAIT_WR(A_WR), .TURN(A_TURN)) dut_a (
        .clk_i(clk), ._reset_i(rst_n),
        .cyc_i(a_cyc), .stb_i(a_stb), .we_i(a_we), .sel_i(a_sel),
        .adr_i(a_adr), .dat_i(a_dat),
        .ack_o(a_ack), .dat_o(a_dout), .stall_o(a_stall),
        ._sram_ce(a_ce), ._sram_we(a_wen), ._sram_oe(a_oe), ._sram_be(a_be),
        .sram_a(a_sa), .sram_d_out(a_dq), .sram_d_oe(a_doe), .sram_d_in(a_din)
    );

    // Behavioural SRAM: 256 words, written while _sram_we and _sram_ce are low.
    logic [15:0] pin_mem [256];
    assign a_din = pin_mem[a_sa[7:0]];

    always @(negedge clk) begin
        if (!a_wen && !a_ce) begin
            for (int b = 0; b < 2; b++) begin
                if (!a_be[b]) pin_mem[a_sa[7:0]][b*8 +: 8] = a_dq[b*8 +: 8];
            end
        end
    end

    // ---------------- instance B ----------------
    logic        b_cyc, b_stb, b_we;
    logic [3:0]  b_sel;
    logic [17:0] b_adr;
    logic [31:0] b_dat;
    logic        b_ack, b_stall, b_ce, b_wen, b_oe, b_doe;
    logic [31:0] b_dout, b_dq, b_din;
    logic [3:0]  b_be;
    logic [17:0] b_sa;

    sram_wb #(.DW(32), .AW(18), .WAIT_RD(0), .WAIT_WR(1), .TURN(0)) dut_b (
        .clk_i(clk), ._reset_i(rst_n),
        .cyc_i(b_cyc), .stb_i(b_stb), .we_i(b_we), .sel_i(b_sel),
        .adr_i(b_adr), .dat_i(b_dat),
        .ack_o(b_ack), .dat_o(b_dout), .stall_o(b_stall),
        ._sram_ce(b_ce), ._sram_we(b_wen), ._sram_oe(b_oe), ._sram_be(b_be),
        .sram_a(b_sa), .sram_d_out(b_dq), .sram_d_oe(b_doe), .sram_d_in(b_din)
    );

    assign b_din = {~b_sa[15:0], b_sa[15:0]};

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pin-level protocol watch on instance A, every cycle out of reset.
    logic        prev_we_lo = 1'b0;
    logic [18:0] prev_a     = '0;
    logic [1:0]  prev_be    = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            check("no_bus_fight", {63'd0, a_doe & ~a_oe}, 64'd0);
            if (!a_wen) check("doe_in_we", {63'd0, a_doe}, 64'd1);
            if (prev_we_lo) begin
                check("addr_stable_we", {45'd0, a_sa}, {45'd0, prev_a});
                check("be_stable_we", {62'd0, a_be}, {62'd0, prev_be});
            end
        end
        prev_we_lo = !a_wen && rst_n;
        prev_a     = a_sa;
        prev_be    = a_be;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- Wishbone master for instance A ----------------
    typedef struct {
        logic        we;
        logic [1:0]  sel;
        logic [18:0] adr;
        logic [15:0] dat;
    } req_t;

    req_t        req_q[$];
    int          acc_q[$];
    int          ack_q[$];
    logic [15:0] ackd_q[$];
    logic [1:0]  be_q[$];
    logic [18:0] sa_q[$];
    logic [63:0] m_oe, m_we, m_doe, m_stall, m_ack, m_ce;

    // Presents queued requests back to back with stb held through stall,
    // recording per-cycle strobe masks (cycle 0 = first request presented).
    // From cycle drop_at onward cyc is dropped and no more requests go out.
    task automatic run(input int ncyc, input int drop_at);
        logic presenting = 1'b0;
        logic just_acc   = 1'b0;
        logic dropped    = 1'b0;
        req_t r;
        acc_q.delete(); ack_q.delete(); ackd_q.delete(); be_q.delete(); sa_q.delete();
        m_oe = '0; m_we = '0; m_doe = '0; m_stall = '0; m_ack = '0; m_ce = '0;
        for (int i = 0; i < ncyc; i++) begin
            if (i == drop_at) begin
                dropped = 1'b1; presenting = 1'b0;
                a_cyc = 1'b0; a_stb = 1'b0;
                req_q.delete();
            end else if (!dropped && !presenting && req_q.size() > 0) begin
                r = req_q.pop_front();
                a_we = r.we; a_sel = r.sel; a_adr = r.adr; a_dat = r.dat;
                a_cyc = 1'b1; a_stb = 1'b1; presenting = 1'b1;
            end
            @(negedge clk);
            if (i < 64) begin
                m_oe[i] = !a_oe; m_we[i] = !a_wen; m_doe[i] = a_doe;
                m_stall[i] = a_stall; m_ack[i] = a_ack; m_ce[i] = !a_ce;
            end
            if (just_acc) begin
                be_q.push_back(a_be); sa_q.push_back(a_sa); just_acc = 1'b0;
            end
            if (a_ack) begin
                ack_q.push_back(i); ackd_q.push_back(a_dout);
            end
            if (presenting && !a_stall) begin
                acc_q.push_back(i); presenting = 1'b0; just_acc = 1'b1;
            end
            tick();
            if (!presenting) a_stb = 1'b0;
        end
        a_cyc = 1'b0; a_stb = 1'b0;
    endtask

    function automatic int first_idle_after(input int from);
        for (int i = from; i < 64; i++) if (!m_stall[i]) return i;
        return -1;
    endfunction

    // ---------------- single read on instance B ----------------
    task automatic b_read(input logic [17:0] adr, input logic [3:0] sel);
        b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b0; b_sel = sel; b_adr = adr;
        @(negedge clk);
        check("b_accept_nostall", {63'd0, b_stall}, 64'd0);
        tick();
        b_stb = 1'b0;
        @(negedge clk);
        check("b_be_tracks_sel", {60'd0, b_be}, {60'd0, ~sel});
        check("b_oe_low_c1", {63'd0, b_oe}, 64'd0);
        tick();
        @(negedge clk);
        check("b_ack_c2", {63'd0, b_ack}, 64'd1);
        check("b_dat", {32'd0, b_dout}, {32'd0, ~adr[15:0], adr[15:0]});
        check("b_idle_at_ack", {63'd0, b_stall}, 64'd0);
        tick();
        b_cyc = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [1:0]  sel;
        logic [18:0] adr;
        logic [15:0] dat;
        logic [1:0]  exp_be;
        int          exp_ack;
        logic [15:0] exp_dat;
        int          exp_idle;
    } vec_t;

    vec_t vecs[7];

    logic [15:0] ref_mem [16];
    int          exp_acc[$];
    int          exp_ack[$];
    logic [15:0] exp_dat[$];
    logic [1:0]  exp_be[$];
    logic [18:0] exp_sa[$];

    initial begin
        int t;
        int ack_t;
        logic [15:0] last_rd;
        req_t r;

        vecs[0] = '{1'b0, 2'b11, 19'h00123, 16'h0000, 2'b00, 3, 16'hF00D, 4};
        vecs[1] = '{1'b1, 2'b10, 19'h00040, 16'hBEEF, 2'b01, 4, 16'hF00D, 5};
        vecs[2] = '{1'b0, 2'b11, 19'h00040, 16'h0000, 2'b00, 3, 16'hBE34, 4};
        vecs[3] = '{1'b1, 2'b00, 19'h00041, 16'hFFFF, 2'b11, 4, 16'hBE34, 5};
        vecs[4] = '{1'b0, 2'b11, 19'h00041, 16'h0000, 2'b00, 3, 16'h0000, 4};
        vecs[5] = '{1'b1, 2'b01, 19'h00041, 16'h5A5A, 2'b10, 4, 16'h0000, 5};
        vecs[6] = '{1'b0, 2'b01, 19'h00041, 16'h0000, 2'b10, 3, 16'h005A, 4};

        for (int i = 0; i < 256; i++) pin_mem[i] = 16'($urandom);
        pin_mem[8'h23] = 16'hF00D;
        pin_mem[8'h40] = 16'h1234;
        pin_mem[8'h41] = 16'h0000;

        a_cyc = 0; a_stb = 0; a_we = 0; a_sel = 0; a_adr = 0; a_dat = 0;
        b_cyc = 0; b_stb = 0; b_we = 0; b_sel = 0; b_adr = 0; b_dat = 0;

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        @(negedge clk);
        check("rst_strobes", {61'd0, a_ce, a_wen, a_oe}, 64'h7);
        check("rst_be", {62'd0, a_be}, 64'h3);
        check("rst_addr_data", {29'd0, a_sa, a_dq}, 64'd0);
        check("rst_doe_ack_stall", {61'd0, a_doe, a_ack, a_stall}, 64'd0);
        check("rst_dat_o", {48'd0, a_dout}, 64'd0);
        check("rst_b_be", {60'd0, b_be}, 64'hF);
        tick();
        rst_n = 1'b1;
        tick();

        // Table-driven single transactions
        foreach (vecs[k]) begin
            r = '{vecs[k].we, vecs[k].sel, vecs[k].adr, vecs[k].dat};
            req_q.push_back(r);
            run(8, -1);
            check($sformatf("v%0d_accept", k), (acc_q.size() == 1) ? 64'(acc_q[0]) : 64'hFFFF, 64'd0);
            check($sformatf("v%0d_ack_cycle", k), (ack_q.size() == 1) ? 64'(ack_q[0]) : 64'hFFFF,
                  64'(vecs[k].exp_ack));
            check($sformatf("v%0d_dat_o", k), (ackd_q.size() == 1) ? 64'(ackd_q[0]) : 64'hFFFFF,
                  64'(vecs[k].exp_dat));
            check($sformatf("v%0d_be", k), (be_q.size() == 1) ? 64'(be_q[0]) : 64'hFF,
                  64'(vecs[k].exp_be));
            check($sformatf("v%0d_addr", k), (sa_q.size() == 1) ? 64'(sa_q[0]) : 64'hFFFFFF,
                  64'(vecs[k].adr));
            check($sformatf("v%0d_next_accept", k),
                  64'(first_idle_after((ack_q.size() > 0) ? ack_q[0] : 0)), 64'(vecs[k].exp_idle));
        end

        // Read waveform: oe low 1-2, stall 1-3, ack 3
        req_q.push_back('{1'b0, 2'b11, 19'h00123, 16'h0000});
        run(8, -1);
        check("rd_oe_window", m_oe, 64'h06);
        check("rd_ce_window", m_ce, 64'h06);
        check("rd_stall", m_stall, 64'h0E);
        check("rd_ack", m_ack, 64'h08);
        check("rd_no_doe", m_doe | m_we, 64'h00);

        // Write waveform: we low 1-3, doe 1-4, ack 4
        req_q.push_back('{1'b1, 2'b10, 19'h00050, 16'hBEEF});
        run(8, -1);
        check("wr_we_window", m_we, 64'h0E);
        check("wr_doe_window", m_doe, 64'h1E);
        check("wr_ce_window", m_ce, 64'h1E);
        check("wr_stall", m_stall, 64'h1E);
        check("wr_ack", m_ack, 64'h10);
        check("wr_be", (be_q.size() > 0) ? 64'(be_q[0]) : 64'hFF, 64'h1);
        check("wr_mem", 64'(pin_mem[8'h50]), {48'd0, 16'hBE, pin_mem[8'h50][7:0]});

        // Back-to-back read then write with stb held through stall
        req_q.push_back('{1'b0, 2'b11, 19'h00023, 16'h0000});
        req_q.push_back('{1'b1, 2'b11, 19'h00051, 16'hC0DE});
        run(14, -1);
        check("b2b_accepts", (acc_q.size() == 2) ? 64'(acc_q[1]) : 64'hFFFF, 64'd4);
        check("b2b_oe", m_oe, 64'h006);
        check("b2b_we", m_we, 64'h0E0);
        check("b2b_doe", m_doe, 64'h1E0);
        check("b2b_stall", m_stall, 64'h1EE);
        check("b2b_ack", m_ack, 64'h108);
        check("b2b_overlap", m_doe & m_oe, 64'h0);

        // cyc dropped in cycle 2 of a write: window completes, no ack
        req_q.push_back('{1'b1, 2'b11, 19'h00052, 16'h1111});
        run(8, 2);
        check("drop_we_window", m_we, 64'h0E);
        check("drop_doe_window", m_doe, 64'h1E);
        check("drop_no_ack", m_ack, 64'h00);
        check("drop_mem", 64'(pin_mem[8'h52]), 64'h1111);

        // Instance B: zero-wait reads, 4-bit byte enables
        b_read(18'h00001, 4'b0001);
        b_read(18'h2ABCD, 4'b1010);
        b_read(18'h1FFFF, 4'b0000);
        b_read(18'h00000, 4'b1111);

        // Reset held 2 cycles in the middle of a write
        a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b1; a_sel = 2'b11; a_adr = 19'h00060; a_dat = 16'h7777;
        tick();
        a_stb = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("midrst_strobes", {61'd0, a_ce, a_wen, a_oe}, 64'h7);
        check("midrst_doe_ack", {62'd0, a_doe, a_ack}, 64'd0);
        check("midrst_stall", {63'd0, a_stall}, 64'd0);
        tick();
        rst_n = 1'b1;
        a_cyc = 1'b0;
        tick();

        // Randomised run against a transaction-level model
        for (int i = 0; i < 16; i++) begin
            pin_mem[i] = 16'($urandom);
            ref_mem[i] = pin_mem[i];
        end
        last_rd = 16'h0000;
        t = 0;
        for (int k = 0; k < 40; k++) begin
            r.we  = 1'($urandom);
            r.sel = 2'($urandom);
            r.adr = 19'($urandom_range(0, 15));
            r.dat = 16'($urandom);
            req_q.push_back(r);
            exp_acc.push_back(t);
            exp_be.push_back(~r.sel);
            exp_sa.push_back(r.adr);
            if (r.we) begin
                ack_t = t + A_WR + 2;
                for (int b = 0; b < 2; b++)
                    if (r.sel[b]) ref_mem[r.adr[3:0]][b*8 +: 8] = r.dat[b*8 +: 8];
                t = ack_t + 1;
            end else begin
                ack_t = t + A_RD + 2;
                last_rd = ref_mem[r.adr[3:0]];
                t = ack_t + A_TURN;
            end
            exp_ack.push_back(ack_t);
            exp_dat.push_back(last_rd);
        end
        run(t + 4, -1);
        check("rnd_accept_count", 64'(acc_q.size()), 64'd40);
        check("rnd_ack_count", 64'(ack_q.size()), 64'd40);
        for (int k = 0; k < 40; k++) begin
            if (k < acc_q.size())
                check($sformatf("rnd%0d_accept", k), 64'(acc_q[k]), 64'(exp_acc[k]));
            if (k < ack_q.size()) begin
                check($sformatf("rnd%0d_ack", k), 64'(ack_q[k]), 64'(exp_ack[k]));
                check($sformatf("rnd%0d_dat", k), 64'(ackd_q[k]), 64'(exp_dat[k]));
            end
            if (k < be_q.size()) begin
                check($sformatf("rnd%0d_be", k), 64'(be_q[k]), 64'(exp_be[k]));
                check($sformatf("rnd%0d_addr", k), 64'(sa_q[k]), 64'(exp_sa[k]));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
